regfile_wb_arbiter: RTL and testbench

Write-back arbiter sitting on the write side of the 32×32 integer register file. It merges single-cycle ALU results with variable-latency load responses into the register file's single write port. Load responses are buffered in a small queue, and queued loads superseded by a younger ALU write are squashed. It also exports a busy mask of registers with pending load data, which decode uses for hazard stalls.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_queue.sv | 79 +++++++
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared constants and the queued load-response entry type for the
// register-file write-back arbiter.
package wb_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef struct packed {
    logic              live;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

  localparam wb_entry_t WB_ENTRY_ZERO = '{live: 1'b0, rd: 5'd0, data: 32'd0};

endpackage

// File: rtl/wb_queue.sv
// Load-response FIFO with per-entry squash; also tracks which registers
// still have live queued data and how many live entries remain.
module wb_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  input  logic                       kill_en,
  input  logic [REG_AW-1:0]          kill_rd,
  output wb_entry_t                  head,
  output logic                       full,
  output logic                       empty,
  output logic [31:0]                live_mask,
  output logic [$clog2(DEPTH):0]     live_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  wb_entry_t       mem_r     [DEPTH];
  wb_entry_t       mem_nxt_s [DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [CW-1:0]   count_r;
  logic [31:0]     mask_nxt_s;
  logic [CW-1:0]   live_nxt_s;

  assign head  = mem_r[rd_ptr_r];
  assign full  = (count_r == CW'(DEPTH));
  assign empty = (count_r == {CW{1'b0}});

  // Next entry contents: popped and squashed slots lose their live bit, so
  // unoccupied slots never contribute to the live mask or count.
  always_comb begin
    mask_nxt_s = 32'd0;
    live_nxt_s = {CW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (push && (AW'(i) == wr_ptr_r)) begin
        mem_nxt_s[i] = push_entry;
      end else begin
        mem_nxt_s[i]      = mem_r[i];
        mem_nxt_s[i].live = mem_r[i].live
                            && !(kill_en && (mem_r[i].rd == kill_rd))
                            && !(pop && (AW'(i) == rd_ptr_r));
      end
      mask_nxt_s = mask_nxt_s | ({31'd0, mem_nxt_s[i].live} << mem_nxt_s[i].rd);
      live_nxt_s = live_nxt_s + CW'(mem_nxt_s[i].live);
    end
  end

  // Storage, pointers and registered live summaries.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= WB_ENTRY_ZERO;
      end
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      live_mask  <= 32'd0;
      live_count <= {CW{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= mem_nxt_s[i];
      end
      wr_ptr_r   <= wr_ptr_r + AW'(push);
      rd_ptr_r   <= rd_ptr_r + AW'(pop);
      count_r    <= count_r + CW'(push) - CW'(pop);
      live_mask  <= mask_nxt_s;
      live_count <= live_nxt_s;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU results and buffered load responses onto the register file's
// single write port; younger ALU writes squash older queued loads.
module regfile_wb_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        alu_valid,
  input  logic [wb_pkg::REG_AW-1:0]   alu_rd,
  input  logic [XLEN-1:0]             alu_data,
  input  logic                        ld_valid,
  output logic                        ld_ready,
  input  logic [wb_pkg::REG_AW-1:0]   ld_rd,
  input  logic [XLEN-1:0]             ld_data,
  output logic                        rf_write,
  output logic [wb_pkg::REG_AW-1:0]   rf_w_addr,
  output logic [XLEN-1:0]             rf_w_data,
  output logic [31:0]                 busy_mask,
  output logic [$clog2(DEPTH):0]      ld_pending
);

  import wb_pkg::*;

  logic        alu_wr_s;
  logic        ld_keep_s;
  logic        head_live_s;
  logic        head_dead_s;
  logic        bypass_s;
  logic        push_s;
  logic        pop_s;
  logic        full_s;
  logic        empty_s;
  wb_entry_t   head_s;
  wb_entry_t   push_entry_s;
  logic        wr_nxt_s;
  logic [REG_AW-1:0] addr_nxt_s;
  logic [XLEN-1:0]   data_nxt_s;

  assign ld_ready = !rst && !full_s;

  // Write-port priority: ALU, then live queue head, then same-cycle bypass.
  always_comb begin
    alu_wr_s    = alu_valid && (alu_rd != 5'd0);
    ld_keep_s   = ld_valid && ld_ready && (ld_rd != 5'd0);
    head_live_s = !empty_s && head_s.live;
    head_dead_s = !empty_s && !head_s.live;
    pop_s       = head_dead_s || (head_live_s && !alu_wr_s);
    bypass_s    = ld_keep_s && empty_s && !alu_wr_s;
    push_s      = ld_keep_s && !bypass_s;

    // A same-cycle ALU write to the same rd is program-younger.
    push_entry_s.live = !(alu_wr_s && (alu_rd == ld_rd));
    push_entry_s.rd   = ld_rd;
    push_entry_s.data = ld_data;

    if (alu_wr_s) begin
      wr_nxt_s   = 1'b1;
      addr_nxt_s = alu_rd;
      data_nxt_s = alu_data;
    end else if (head_live_s) begin
      wr_nxt_s   = 1'b1;
      addr_nxt_s = head_s.rd;
      data_nxt_s = head_s.data;
    end else if (bypass_s) begin
      wr_nxt_s   = 1'b1;
      addr_nxt_s = ld_rd;
      data_nxt_s = ld_data;
    end else begin
      wr_nxt_s   = 1'b0;
      addr_nxt_s = rf_w_addr;
      data_nxt_s = rf_w_data;
    end
  end

  // Registered register-file write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_write  <= 1'b0;
      rf_w_addr <= 5'd0;
      rf_w_data <= {XLEN{1'b0}};
    end else begin
      rf_write  <= wr_nxt_s;
      rf_w_addr <= addr_nxt_s;
      rf_w_data <= data_nxt_s;
    end
  end

  wb_queue #(.DEPTH(DEPTH)) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_entry (push_entry_s),
    .pop        (pop_s),
    .kill_en    (alu_wr_s),
    .kill_rd    (alu_rd),
    .head       (head_s),
    .full       (full_s),
    .empty      (empty_s),
    .live_mask  (busy_mask),
    .live_count (ld_pending)
  );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Randomised and directed bench for regfile_wb_arbiter against a queue-based
// reference model of the write-back rules.
module tb_regfile_wb_arbiter;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        rf_write;
  logic [4:0]  rf_w_addr;
  logic [31:0] rf_w_data;
  logic [31:0] busy_mask;
  logic [2:0]  ld_pending;

  regfile_wb_arbiter #(.XLEN(32), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .alu_valid  (alu_valid),
    .alu_rd     (alu_rd),
    .alu_data   (alu_data),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_rd      (ld_rd),
    .ld_data    (ld_data),
    .rf_write   (rf_write),
    .rf_w_addr  (rf_w_addr),
    .rf_w_data  (rf_w_data),
    .busy_mask  (busy_mask),
    .ld_pending (ld_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       live;
    bit [4:0] rd;
    bit [31:0] data;
  } m_ent_t;

  m_ent_t    m_q[$];
  bit        m_write;
  bit [4:0]  m_addr;
  bit [31:0] m_data;
  int        n_checks = 0;
  int        n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock of the write-back rules applied to the model queue.
  task automatic model_step(input bit av, input bit [4:0] ar, input bit [31:0] ad,
                            input bit acc, input bit [4:0] lr, input bit [31:0] ldd,
                            input bit r);
    bit aw;
    bit was_empty;
    bit head_live;
    bit bypass;
    if (r) begin
      m_q.delete();
      m_write = 0; m_addr = 0; m_data = 0;
      return;
    end
    aw        = av && (ar != 0);
    was_empty = (m_q.size() == 0);
    head_live = !was_empty && m_q[0].live;
    bypass    = 0;
    m_write   = 0;
    if (aw) begin
      m_write = 1; m_addr = ar; m_data = ad;
      if (!was_empty && !head_live) void'(m_q.pop_front());
      foreach (m_q[i]) if (m_q[i].rd == ar) m_q[i].live = 0;
    end else if (head_live) begin
      m_write = 1; m_addr = m_q[0].rd; m_data = m_q[0].data;
      void'(m_q.pop_front());
    end else begin
      if (!was_empty) void'(m_q.pop_front());
      if (acc && lr != 0 && was_empty) begin
        bypass = 1;
        m_write = 1; m_addr = lr; m_data = ldd;
      end
    end
    if (acc && lr != 0 && !bypass)
      m_q.push_back('{live: !(aw && ar == lr), rd: lr, data: ldd});
  endtask

  function automatic bit [31:0] m_mask();
    bit [31:0] m = 0;
    foreach (m_q[i]) if (m_q[i].live) m[m_q[i].rd] = 1;
    return m;
  endfunction

  function automatic int m_pend();
    int n = 0;
    foreach (m_q[i]) if (m_q[i].live) n++;
    return n;
  endfunction

  task automatic cycle(input bit av, input bit [4:0] ar, input bit [31:0] ad,
                       input bit lv, input bit [4:0] lr, input bit [31:0] ldd,
                       input bit r);
    bit acc;
    alu_valid = av; alu_rd = ar; alu_data = ad;
    ld_valid  = lv; ld_rd  = lr; ld_data  = ldd;
    rst = r;
    #1;
    acc = !r && (m_q.size() < DEPTH);
    check("ld_ready", {63'd0, ld_ready}, {63'd0, acc});
    acc = acc && lv;
    @(posedge clk);
    #1;
    model_step(av, ar, ad, acc, lr, ldd, r);
    check("rf_write",   {63'd0, rf_write},   {63'd0, m_write});
    check("rf_w_addr",  {59'd0, rf_w_addr},  {59'd0, m_addr});
    check("rf_w_data",  {32'd0, rf_w_data},  {32'd0, m_data});
    check("busy_mask",  {32'd0, busy_mask},  {32'd0, m_mask()});
    check("ld_pending", {61'd0, ld_pending}, 64'(m_pend()));
  endtask

  task automatic idle();
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 0);
  endtask

  initial begin
    rst = 1'b1;
    alu_valid = 1'b0; alu_rd = 5'd0; alu_data = 32'd0;
    ld_valid  = 1'b0; ld_rd  = 5'd0; ld_data  = 32'd0;

    // Reset for two cycles.
    cycle(0, 5'd0, 32'd0, 1, 5'd3, 32'd1, 1);
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
    check("reset_rf_write", {63'd0, rf_write}, 64'd0);
    check("reset_ready", {63'd0, ld_ready}, 64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_reset", {63'd0, ld_ready}, 64'd1);

    // ALU write and x0 filtering.
    cycle(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'd0, 0);
    check("alu_addr", {59'd0, rf_w_addr}, 64'd5);
    check("alu_data", {32'd0, rf_w_data}, 64'hDEADBEEF);
    cycle(1, 5'd0, 32'h12345678, 0, 5'd0, 32'd0, 0);
    check("alu_x0_nowrite", {63'd0, rf_write}, 64'd0);

    // Load bypass, then load behind a concurrent ALU write.
    cycle(0, 5'd0, 32'd0, 1, 5'd7, 32'hA5A5_0007, 0);
    check("bypass_addr", {59'd0, rf_w_addr}, 64'd7);
    cycle(1, 5'd10, 32'h0000_0010, 1, 5'd7, 32'hB7B7_0007, 0);
    check("alu_first_addr", {59'd0, rf_w_addr}, 64'd10);
    check("busy7", {63'd0, busy_mask[7]}, 64'd1);
    idle();
    check("queued_load_data", {32'd0, rf_w_data}, 64'hB7B7_0007);

    // Fill the queue under ALU traffic, then drain in order.
    for (int i = 1; i <= 4; i++)
      cycle(1, 5'd20, 32'(i), 1, 5'(i), 32'h100 + 32'(i), 0);
    check("full_ready", {63'd0, ld_ready}, 64'd0);
    check("full_pending", {61'd0, ld_pending}, 64'd4);
    for (int i = 1; i <= 4; i++) begin
      idle();
      check("drain_addr", {59'd0, rf_w_addr}, 64'(i));
      if (i == 1) check("ready_after_pop", {63'd0, ld_ready}, 64'd1);
    end

    // Squash a queued load, and a same-cycle load/ALU collision.
    cycle(1, 5'd11, 32'h0000_0011, 1, 5'd9, 32'hAAAA_AAAA, 0);
    check("busy9_set", {63'd0, busy_mask[9]}, 64'd1);
    cycle(1, 5'd9, 32'hBBBB_BBBB, 0, 5'd0, 32'd0, 0);
    check("busy9_clear", {63'd0, busy_mask[9]}, 64'd0);
    check("squash_pending", {61'd0, ld_pending}, 64'd0);
    idle();
    check("dead_pop_nowrite", {63'd0, rf_write}, 64'd0);
    cycle(1, 5'd3, 32'hC0DE_0003, 1, 5'd3, 32'hBAD0_0003, 0);
    check("collide_data", {32'd0, rf_w_data}, 64'hC0DE_0003);
    idle();
    check("collide_nowrite", {63'd0, rf_write}, 64'd0);
    idle();

    // Reset while three loads are queued.
    for (int i = 1; i <= 3; i++)
      cycle(1, 5'd21, 32'(i), 1, 5'(i + 12), 32'h200 + 32'(i), 0);
    cycle(0, 5'd0, 32'd0, 0, 5'd0, 32'd0, 1);
    check("rst_pending", {61'd0, ld_pending}, 64'd0);
    check("rst_mask", {32'd0, busy_mask}, 64'd0);
    check("rst_write", {63'd0, rf_write}, 64'd0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("no_stale_write", {63'd0, rf_write}, 64'd0);
    end

    // Randomised traffic with a small register range to provoke hazards.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 2) != 0), 5'($urandom_range(0, 7)), $urandom,
            ($urandom_range(0, 63) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
